// File: rtl/muestreo_pkg.sv
`default_nettype none
// ============================================================================
// muestreo_pkg : shared widths, state encoding and defaults for the ADC sampler
// Rev 1.0
// ============================================================================
package muestreo_pkg;

  localparam int SAMPLE_W = 25;

  localparam int DEF_PERIOD     = 1000;
  localparam int DEF_SCLK_HALF  = 4;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_ADC_BITS   = 12;
  localparam int DEF_SHIFT      = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : muestreo_pkg
`default_nettype wire

// File: rtl/adc_a_q.sv
`default_nettype none
// ============================================================================
// adc_a_q : offset-binary ADC code to left-shifted 25-bit two's complement
// Rev 1.0
// ============================================================================
module adc_a_q
  import muestreo_pkg::*;
#(
  parameter int ADC_BITS = DEF_ADC_BITS,
  parameter int SHIFT    = DEF_SHIFT
) (
  input  logic [ADC_BITS-1:0] code,
  output logic [SAMPLE_W-1:0] sample
);

  logic [ADC_BITS-1:0] s;
  logic [SAMPLE_W-1:0] ext;

  // Inverting the MSB turns offset binary into two's complement.
  assign s = {~code[ADC_BITS-1], code[ADC_BITS-2:0]};

  generate
    if (ADC_BITS < SAMPLE_W) begin : g_ext
      assign ext = {{(SAMPLE_W-ADC_BITS){s[ADC_BITS-1]}}, s};
    end else begin : g_full
      assign ext = s;
    end
  endgenerate

  assign sample = ext << SHIFT;

endmodule : adc_a_q
`default_nettype wire

// File: rtl/muestreador_adc.sv
`default_nettype none
// ============================================================================
// muestreador_adc : periodic 3-wire SPI ADC reader producing a strobed sample
// Rev 1.0
// ============================================================================
module muestreador_adc
  import muestreo_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int SCLK_HALF  = DEF_SCLK_HALF,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int ADC_BITS   = DEF_ADC_BITS,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sdata,
  output logic                cs_n,
  output logic                sclk,
  output logic                tx,
  output logic [SAMPLE_W-1:0] u
);

  localparam int PW = $clog2(PERIOD);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS);

  generate
    if (PERIOD < 16 || PERIOD < SCLK_HALF*(2*FRAME_BITS+1)+4) begin : g_bad_period
      $error("muestreador_adc: PERIOD too short for one frame");
    end
    if (SCLK_HALF < 1) begin : g_bad_half
      $error("muestreador_adc: SCLK_HALF must be at least 1");
    end
    if (ADC_BITS + SHIFT > SAMPLE_W || ADC_BITS < 2 || ADC_BITS > FRAME_BITS) begin : g_bad_width
      $error("muestreador_adc: ADC_BITS/SHIFT do not fit the sample grid");
    end
  endgenerate

  logic [1:0]          state;
  logic [PW-1:0]       pcnt;
  logic [HW-1:0]       hcnt;
  logic [BW-1:0]       bcnt;
  logic [ADC_BITS-1:0] sreg;
  logic [SAMPLE_W-1:0] u_next;

  // Leading header bits fall off the top, leaving exactly the code bits.
  adc_a_q #(
    .ADC_BITS (ADC_BITS),
    .SHIFT    (SHIFT)
  ) u_conv (
    .code   (sreg),
    .sample (u_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (enable || state != ST_IDLE) begin
      pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
    end else begin
      pcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cs_n  <= 1'b1;
      sclk  <= 1'b1;
      tx    <= 1'b0;
      u     <= '0;
      hcnt  <= '0;
      bcnt  <= '0;
      sreg  <= '0;
    end else begin
      tx <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && pcnt == '0) begin
            state <= ST_SETUP;
            cs_n  <= 1'b0;
            hcnt  <= '0;
            bcnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (hcnt == H_LAST) begin
            hcnt  <= '0;
            sclk  <= 1'b0;
            state <= ST_SHIFT;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (!sclk) begin
              // Sample on the edge that raises sclk; the ADC moved on the fall.
              sclk <= 1'b1;
              sreg <= {sreg[ADC_BITS-2:0], sdata};
              bcnt <= bcnt + 1'b1;
            end else if (bcnt == B_LAST) begin
              cs_n  <= 1'b1;
              state <= ST_DONE;
            end else begin
              sclk <= 1'b0;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_DONE: begin
          tx    <= 1'b1;
          u     <= u_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : muestreador_adc
`default_nettype wire

// File: tb/tb_muestreador_adc.sv
`default_nettype none
// ============================================================================
// tb_muestreador_adc : directed scoreboard bench with a behavioural SPI ADC
// Rev 1.0
// ============================================================================
module tb_muestreador_adc;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sdata;
  logic        cs_n;
  logic        sclk;
  logic        tx;
  logic [24:0] u;

  always #5 clk = ~clk;

  muestreador_adc dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .sdata  (sdata),
    .cs_n   (cs_n),
    .sclk   (sclk),
    .tx     (tx),
    .u      (u)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] exp_u(input logic [15:0] frame);
    int v;
    v = int'(frame[11:0]) - 2048;
    return 25'(v * 256);
  endfunction

  // Behavioural ADC: MSB valid when selected, next bit after each sclk fall.
  logic [15:0] frame_q[$];
  logic [24:0] exp_q[$];
  logic [15:0] cur_frame;
  int          arises;

  always @(negedge cs_n) begin
    if (frame_q.size() != 0) cur_frame = frame_q.pop_front();
    else                     cur_frame = 16'($urandom);
    exp_q.push_back(exp_u(cur_frame));
    arises = 0;
    sdata  = cur_frame[15];
  end

  always @(posedge sclk) if (!cs_n) arises++;

  always @(negedge sclk) if (!cs_n && arises < 16) sdata = cur_frame[15 - arises];

  // Output monitor
  logic        prev_cs    = 1'b1;
  logic        prev_sclk  = 1'b1;
  logic        skip_frame = 1'b0;
  logic        chk_spacing = 1'b0;
  int          cs_fall_cyc = 0;
  int          mon_rises  = 0;
  int          cs_falls   = 0;
  int          tx_count   = 0;
  int          last_tx    = -1;
  logic [24:0] last_exp_u = '0;
  logic [24:0] e;

  always @(negedge clk) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      cs_fall_cyc = cyc;
      mon_rises   = 0;
      cs_falls++;
      skip_frame  = 1'b0;
    end
    if (cs_n === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) mon_rises++;
    if (prev_cs === 1'b0 && cs_n === 1'b1 && !skip_frame) begin
      chk("cs_low_len", cyc - cs_fall_cyc, 132);
      chk("sclk_rises", mon_rises, 16);
    end
    if (tx === 1'b1) begin
      tx_count++;
      chk("tx_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp_u = e;
        chk("u_value", 32'(u), 32'(e));
      end
      chk("tx_latency", cyc - cs_fall_cyc, 133);
      if (chk_spacing && last_tx >= 0) chk("tx_spacing", cyc - last_tx, 1000);
      last_tx = cyc;
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tx", 32'(tx_count >= target), 1);
  endtask

  task automatic wait_cs_fall(input int target, input int budget);
    int n = 0;
    while (cs_falls < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cs_fall", 32'(cs_falls >= target), 1);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    sdata  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sclk", 32'(sclk), 1);
    chk("rst_tx",   32'(tx), 0);
    chk("rst_u",    32'(u), 0);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    chk("idle_cs_n", 32'(cs_n), 1);
    chk("idle_no_tx", tx_count, 0);

    // Five periods: full-scale positive, negative, mid-scale, two random
    frame_q.push_back(16'h0FFF);
    frame_q.push_back(16'h0000);
    frame_q.push_back(16'h0800);
    frame_q.push_back(16'($urandom));
    frame_q.push_back(16'($urandom));
    chk_spacing = 1'b1;
    enable = 1'b1;
    wait_tx(5, 6000);
    enable = 1'b0;
    chk_spacing = 1'b0;
    repeat (1500) @(negedge clk);
    chk("rate_tx_count", tx_count, 5);
    chk("rate_frames", cs_falls, 5);
    chk("u_hold", 32'(u), 32'(last_exp_u));

    // enable dropped 50 cycles into a frame
    frame_q.push_back(16'h0FFF);
    enable = 1'b1;
    wait_cs_fall(6, 20);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    wait_tx(6, 300);
    repeat (2000) @(negedge clk);
    chk("drop_tx_count", tx_count, 6);
    chk("drop_frames", cs_falls, 6);
    chk("drop_cs_n", 32'(cs_n), 1);
    chk("drop_sclk", 32'(sclk), 1);
    chk("drop_u", 32'(u), 32'h007FF00);

    // Asynchronous reset in the middle of a frame
    frame_q.push_back(16'h0123);
    enable = 1'b1;
    wait_cs_fall(7, 20);
    repeat (40) @(negedge clk);
    skip_frame = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(cs_n), 1);
    chk("arst_sclk", 32'(sclk), 1);
    chk("arst_tx",   32'(tx), 0);
    chk("arst_u",    32'(u), 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (200) @(negedge clk);
    chk("arst_no_tx", tx_count, 6);
    chk("arst_idle_cs_n", 32'(cs_n), 1);

    // Recovery with code 0x7FF -> -1 LSB
    frame_q.push_back(16'hA7FF);
    enable = 1'b1;
    wait_tx(7, 300);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("recover_u", 32'(u), 32'h1FFFF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_muestreador_adc
`default_nettype wire
